// File: rtl/nand_bist_pkg.sv
// Shared types and constants for the NAND function-unit BIST sequencer.
// Holds the FSM state encoding, vector count, default truth table and settle-counter width.
package nand_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } bist_state_e;

    localparam int          VEC_COUNT         = 8;
    localparam logic [7:0]  DEFAULT_EXP_TRUTH = 8'h3A;
    localparam int          SETTLE_CNT_W      = 4;

    typedef logic [SETTLE_CNT_W-1:0] settle_cnt_t;

endpackage

// File: rtl/bist_settle_timer.sv
// Loadable down-counter that times how long each vector is held before sampling.
// Load takes priority over decrement; zero flag is combinational from the count.
module bist_settle_timer
    import nand_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  settle_cnt_t load_val,
    input  logic        dec,
    output settle_cnt_t value,
    output logic        zero
);

    settle_cnt_t cnt_q;
    settle_cnt_t cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - settle_cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/nand_bist_ctrl.sv
// Walks the eight {x,y,z} vectors through the function unit, samples F after a settle window
// and compares the collected truth table against EXP_TRUTH; done pulses once per completed run.
module nand_bist_ctrl
    import nand_bist_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] EXP_TRUTH     = DEFAULT_EXP_TRUTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       dut_x,
    output logic       dut_y,
    output logic       dut_z,
    input  logic       dut_f,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [7:0] fail_mask
);

    localparam settle_cnt_t SETTLE_LOAD = settle_cnt_t'(SETTLE_CYCLES - 1);
    localparam logic [2:0]  LAST_VEC    = 3'(VEC_COUNT - 1);

    bist_state_e state_q, state_d;
    logic [2:0]  vec_q, vec_d;
    logic [2:0]  drive_q, drive_d;
    logic [7:0]  captured_q, captured_d;
    logic [7:0]  fail_mask_q, fail_mask_d;
    logic        pass_q, pass_d;

    logic        tmr_load;
    logic        tmr_dec;
    logic        tmr_zero;
    settle_cnt_t tmr_value;

    bist_settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_LOAD),
        .dec      (tmr_dec),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        drive_d     = drive_q;
        captured_d  = captured_q;
        fail_mask_d = fail_mask_q;
        pass_d      = pass_q;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d     = SETTLE;
                    vec_d       = '0;
                    drive_d     = '0;
                    captured_d  = '0;
                    fail_mask_d = '0;
                    pass_d      = 1'b0;
                    tmr_load    = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    drive_d = '0;
                    pass_d  = 1'b0;
                end else if (tmr_zero) begin
                    state_d = SAMPLE;
                end else begin
                    tmr_dec = (tmr_value != '0);
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                    drive_d = '0;
                    pass_d  = 1'b0;
                end else begin
                    captured_d[vec_q]  = dut_f;
                    fail_mask_d[vec_q] = dut_f ^ EXP_TRUTH[vec_q];
                    if (vec_q == LAST_VEC) begin
                        // Verdict uses the freshly sampled vec-7 bit so pass is valid alongside done.
                        state_d = DONE;
                        drive_d = '0;
                        pass_d  = (captured_d == EXP_TRUTH);
                    end else begin
                        state_d  = SETTLE;
                        vec_d    = vec_q + 3'd1;
                        drive_d  = vec_q + 3'd1;
                        tmr_load = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (abort) begin
                    pass_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            drive_q     <= '0;
            captured_q  <= '0;
            fail_mask_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            drive_q     <= drive_d;
            captured_q  <= captured_d;
            fail_mask_q <= fail_mask_d;
            pass_q      <= pass_d;
        end
    end

    assign dut_x     = drive_q[2];
    assign dut_y     = drive_q[1];
    assign dut_z     = drive_q[0];
    assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done      = (state_q == DONE) && !abort;
    assign pass      = pass_q;
    assign captured  = captured_q;
    assign fail_mask = fail_mask_q;

endmodule
